blackbox_sweeper: RTL and testbench
===================================

Name: blackbox_sweeper

Overview:
Controller that sequences the three-input combinational `blackbox` unit (inputs f, x, e; output n) through all 8 input combinations. It holds each combination for a programmable settle time, samples n, and assembles an 8-bit truth table. On completion it compares the truth table against an expected mask and reports pass/fail. It sits between a host/bench (start/done handshake) and one `blackbox` instance, which it owns exclusively.

Parameters:
SETTLE_CYCLES, 2, cycles each combination is held before n is sampled; legal range 1..15.

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  begin a sweep; sampled only in IDLE
abort  input  1  cancel a sweep in progress
expected  input  8  expected truth table; bit i = n for combo i; latched on accepted start
bb_f  output  1  drives blackbox f; combo index bit 2
bb_x  output  1  drives blackbox x; combo index bit 1
bb_e  output  1  drives blackbox e; combo index bit 0
bb_n  input  1  blackbox output n
busy  output  1  high in SETTLE state
done  output  1  one-cycle pulse when a sweep completes normally
aborted  output  1  sticky; set on abort, cleared by the next accepted start
truth_table  output  8  captured n per combo
pass  output  1  truth_table == latched expected; valid from done onward
mismatch_count  output  4  popcount(truth_table XOR expected), range 0..8
first_fail  output  3  lowest index i with a mismatch; 0 when pass=1

Behaviour:
- Reset (async, reset_n=0): state=IDLE, index=0, settle count=0, all outputs 0, latched expected=0.
- States: IDLE, SETTLE, DONE.
- IDLE:
  - bb_f/bb_x/bb_e = 0.
  - start=1 and abort=0: latch expected, clear truth_table/pass/mismatch_count/first_fail/aborted, set index=0, go to SETTLE.
  - start=1 and abort=1 in the same cycle: abort wins; stay IDLE; nothing is latched or cleared.
- SETTLE:
  - {bb_f,bb_x,bb_e} = index (registered outputs).
  - Settle counter runs 0..SETTLE_CYCLES-1.
  - On the edge ending the count SETTLE_CYCLES-1 cycle: truth_table[index] <= bb_n.
  - If index<7: index+1, counter restarts at 0, stay in SETTLE.
  - If index==7: go to DONE.
  - start is ignored in SETTLE.
- DONE:
  - Lasts exactly one cycle. done=1, busy=0, outputs driven to 0.
  - pass, mismatch_count and first_fail are valid this cycle; they are computed combinationally from registered truth_table and expected, then registered on DONE entry.
  - Next state is IDLE.
- Latency: start accepted at edge t; first combo driven from t+1; done high in cycle t+1+8*SETTLE_CYCLES. With SETTLE_CYCLES=2, done follows start by 17 cycles.
- Result retention: results hold unchanged in IDLE until the next accepted start.
- abort=1 in SETTLE:
  - Next state is IDLE; aborted<=1; done is not asserted.
  - truth_table keeps only the bits already sampled.
  - pass, mismatch_count and first_fail stay 0.
  - If abort coincides with the final sample edge, abort wins: bit 7 is not captured and DONE is not entered.
- Reset mid-sweep: returns to reset values immediately, independent of clk.
- Index wrap: index is 3 bits and never wraps; DONE is taken on index 7.
- Width rules: mismatch_count is a 4-bit popcount of the 8-bit XOR. first_fail uses a priority encoder, lowest bit first.

Decomposition:
- Package blackbox_sweeper_pkg contains:
  - state enum {IDLE, SETTLE, DONE}
  - NUM_COMBOS=8
  - IDX_W=3
  - bit positions F_BIT=2, X_BIT=1, E_BIT=0
- One sub-module, settle_timer: counter with load/clear, a terminal-count output, and a SETTLE_CYCLES parameter.
- The popcount and priority encoder stay inline in the top module.

Test Plan:
- Bench blackbox model n=x&e, SETTLE_CYCLES=2, expected=8'h88, start pulse -> busy for 16 cycles, combos 0..7 driven in order with 2 cycles each, done at start+17, truth_table=8'h88, pass=1, mismatch_count=0, first_fail=0.
- Same model, expected=8'h80 -> truth_table=8'h88, pass=0, mismatch_count=1, first_fail=3.
- Same model, expected=8'h77 -> mismatch_count=8, first_fail=0, pass=0.
- abort asserted while index=4 -> next cycle IDLE, aborted=1, no done pulse, truth_table=8'h08 (bits 0..3 sampled), pass=0; a following start clears aborted and runs a full sweep.
- start re-pulsed while busy, plus start and abort together in IDLE -> start is ignored in both cases; done timing is unchanged from the first start.
- reset_n dropped mid-SETTLE, between clock edges -> all outputs 0 immediately; after release, state is IDLE and a new start gives done after exactly 1+8*SETTLE_CYCLES cycles.

Source files
------------

// File: rtl/blackbox_sweeper_pkg.sv
// Shared types and constants for the blackbox truth-table sweeper.
package blackbox_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int NUM_COMBOS = 8;
  localparam int IDX_W      = 3;
  localparam int F_BIT      = 2;
  localparam int X_BIT      = 1;
  localparam int E_BIT      = 0;

endpackage

// File: rtl/settle_timer.sv
// Settle-time counter: counts 0..SETTLE_CYCLES-1 while enabled, flags the last count.
module settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  logic [3:0] count_r;

  // Count register; clear has priority and the count restarts after the terminal value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= 4'd0;
    end else if (clr) begin
      count_r <= 4'd0;
    end else if (en) begin
      if (count_r == LAST_CNT) begin
        count_r <= 4'd0;
      end else begin
        count_r <= count_r + 4'd1;
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == LAST_CNT);

endmodule

// File: rtl/blackbox_sweeper.sv
// Walks the blackbox through all eight f/x/e combinations, builds its truth
// table and grades it against a mask latched at start.
module blackbox_sweeper
  import blackbox_sweeper_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  output logic       bb_f,
  output logic       bb_x,
  output logic       bb_e,
  input  logic       bb_n,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [7:0] truth_table,
  output logic       pass,
  output logic [3:0] mismatch_count,
  output logic [2:0] first_fail
);

  state_e                  state_r, state_s;
  logic [IDX_W-1:0]        index_r, index_s;
  logic [NUM_COMBOS-1:0]   expected_r;
  logic [NUM_COMBOS-1:0]   tt_s, diff_s;
  logic [3:0]              pop_s;
  logic [2:0]              ff_s;
  logic                    latch_s, sample_s, abort_hit_s;
  logic                    timer_clr_s, timer_en_s, tc_s;

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (timer_clr_s),
    .en      (timer_en_s),
    .tc      (tc_s)
  );

  // Next-state, index and sampling decisions; abort outranks the final sample
  always_comb begin
    state_s     = state_r;
    index_s     = index_r;
    latch_s     = 1'b0;
    sample_s    = 1'b0;
    abort_hit_s = 1'b0;
    timer_clr_s = 1'b1;
    timer_en_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          state_s = SETTLE;
          index_s = 3'd0;
          latch_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SETTLE: begin
        timer_clr_s = 1'b0;
        timer_en_s  = 1'b1;
        if (abort) begin
          state_s     = IDLE;
          abort_hit_s = 1'b1;
          timer_clr_s = 1'b1;
        end else if (tc_s) begin
          sample_s = 1'b1;
          if (index_r == 3'd7) begin
            state_s = DONE;
          end else begin
            index_s = index_r + 3'd1;
          end
        end else begin
          state_s = SETTLE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Truth table as it will look after this edge, plus its grade against the mask
  always_comb begin
    tt_s = truth_table;
    if (latch_s) begin
      tt_s = 8'd0;
    end else if (sample_s) begin
      tt_s[index_r] = bb_n;
    end else begin
      tt_s = truth_table;
    end
    diff_s = tt_s ^ expected_r;
    pop_s  = 4'd0;
    ff_s   = 3'd0;
    for (int i = NUM_COMBOS - 1; i >= 0; i--) begin
      pop_s = pop_s + {3'd0, diff_s[i]};
      if (diff_s[i]) begin
        ff_s = 3'(i);
      end else begin
        ff_s = ff_s;
      end
    end
  end

  // State and registered outputs, all derived from the upcoming state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      index_r        <= 3'd0;
      expected_r     <= 8'd0;
      truth_table    <= 8'd0;
      pass           <= 1'b0;
      mismatch_count <= 4'd0;
      first_fail     <= 3'd0;
      aborted        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bb_f           <= 1'b0;
      bb_x           <= 1'b0;
      bb_e           <= 1'b0;
    end else begin
      state_r     <= state_s;
      index_r     <= index_s;
      truth_table <= tt_s;
      if (latch_s) begin
        expected_r     <= expected;
        pass           <= 1'b0;
        mismatch_count <= 4'd0;
        first_fail     <= 3'd0;
        aborted        <= 1'b0;
      end else if (abort_hit_s) begin
        aborted <= 1'b1;
      end else if (state_s == DONE) begin
        pass           <= (diff_s == 8'd0);
        mismatch_count <= pop_s;
        first_fail     <= ff_s;
      end
      busy <= (state_s == SETTLE);
      done <= (state_s == DONE);
      bb_f <= (state_s == SETTLE) ? index_s[F_BIT] : 1'b0;
      bb_x <= (state_s == SETTLE) ? index_s[X_BIT] : 1'b0;
      bb_e <= (state_s == SETTLE) ? index_s[E_BIT] : 1'b0;
    end
  end

endmodule

// File: tb/tb_blackbox_sweeper.sv
// Randomized self-checking bench: a table-driven blackbox and a
// truth-table reference model graded per sweep.
module tb_blackbox_sweeper;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expected = 8'd0;
  logic       bb_f, bb_x, bb_e, bb_n;
  logic       busy, done, aborted, pass;
  logic [7:0] truth_table;
  logic [3:0] mismatch_count;
  logic [2:0] first_fail;
  logic [7:0] bb_fn = 8'h88;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural blackbox: output n looked up from a function table by combo index
  assign bb_n = bb_fn[{bb_f, bb_x, bb_e}];

  blackbox_sweeper #(.SETTLE_CYCLES(S)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .expected       (expected),
    .bb_f           (bb_f),
    .bb_x           (bb_x),
    .bb_e           (bb_e),
    .bb_n           (bb_n),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .truth_table    (truth_table),
    .pass           (pass),
    .mismatch_count (mismatch_count),
    .first_fail     (first_fail)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [2:0] ref_first_fail(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      if (d[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  // One sweep; abort_cyc < 0 means run to completion, else abort during cycle abort_cyc after start
  task automatic sweep(input logic [7:0] exp_v, input logic [7:0] fn, input int abort_cyc, input bit repulse);
    int busy_cnt = 0;
    int done_cyc = -1;
    int done_cnt = 0;
    int bad_combo = 0;
    logic [7:0] ref_tt;
    @(negedge clk);
    bb_fn = fn;
    expected = exp_v;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    expected = ~exp_v;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) begin
        if ({bb_f, bb_x, bb_e} != 3'(busy_cnt / S)) bad_combo++;
        busy_cnt++;
      end else if ({bb_f, bb_x, bb_e} != 3'd0) begin
        bad_combo++;
      end
      if (done) begin
        if (done_cyc < 0) done_cyc = k;
        done_cnt++;
      end
      abort = (k == abort_cyc);
      start = repulse && (k == 5);
    end
    abort = 1'b0;
    start = 1'b0;
    check_eq("combo_order", bad_combo, 0);
    if (abort_cyc < 0) begin
      ref_tt = 8'd0;
      for (int i = 0; i < 8; i++) ref_tt[i] = fn[i];
      check_eq("done_latency", done_cyc, 1 + 8 * S);
      check_eq("done_pulses", done_cnt, 1);
      check_eq("busy_cycles", busy_cnt, 8 * S);
      check_eq("truth_table", truth_table, ref_tt);
      check_eq("pass", pass, ref_tt == exp_v);
      check_eq("mismatch_count", mismatch_count, $countones(ref_tt ^ exp_v));
      check_eq("first_fail", first_fail, ref_first_fail(ref_tt ^ exp_v));
      check_eq("aborted_clear", aborted, 0);
    end else begin
      ref_tt = 8'd0;
      for (int i = 0; i < 8; i++) begin
        if (S * (i + 1) < abort_cyc) ref_tt[i] = fn[i];
      end
      check_eq("abort_no_done", done_cnt, 0);
      check_eq("abort_busy_cycles", busy_cnt, abort_cyc);
      check_eq("abort_truth_table", truth_table, ref_tt);
      check_eq("abort_pass", pass, 0);
      check_eq("abort_mismatch", mismatch_count, 0);
      check_eq("abort_first_fail", first_fail, 0);
      check_eq("aborted_set", aborted, 1);
    end
  endtask

  initial begin
    logic [7:0] tt_before;
    logic [7:0] fn_r, exp_r;
    int ab;

    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs",
             {busy, done, aborted, pass, bb_f, bb_x, bb_e, truth_table, mismatch_count, first_fail}, 0);
    reset_n = 1'b1;

    sweep(8'h88, 8'h88, -1, 1'b0);
    sweep(8'h80, 8'h88, -1, 1'b0);
    sweep(8'h77, 8'h88, -1, 1'b0);
    sweep(8'h88, 8'h88, 9, 1'b0);
    sweep(8'h88, 8'h88, -1, 1'b0);
    sweep(8'h88, 8'h88, 16, 1'b0);
    sweep(8'h88, 8'h88, 1, 1'b0);
    sweep(8'h5a, 8'h88, -1, 1'b1);

    // start together with abort in IDLE must be ignored
    tt_before = truth_table;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    expected = 8'h00;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("start_abort_idle_busy", busy, 0);
    check_eq("start_abort_idle_tt", truth_table, tt_before);
    check_eq("start_abort_idle_mm", mismatch_count, $countones(8'h88 ^ 8'h5a));

    // asynchronous reset in the middle of a sweep
    @(negedge clk);
    bb_fn = 8'h88;
    expected = 8'h88;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("pre_reset_tt", truth_table, 8'h08);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midreset_outputs",
             {busy, done, aborted, pass, bb_f, bb_x, bb_e, truth_table, mismatch_count, first_fail}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    sweep(8'h88, 8'h88, -1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      fn_r  = 8'($urandom);
      exp_r = (r % 2 == 1) ? fn_r : 8'($urandom);
      ab    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : -1;
      sweep(exp_r, fn_r, ab, r[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
